// File: rtl/main_fsm_g7_pkg.sv
// Shared encodings for the multicycle main control FSM: state codes, opcodes,
// ALUOp codes and datapath mux selects.
package main_fsm_g7_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // States whose exit to FETCH marks the end of a completed instruction.
    function automatic logic is_final_state(input state_e s);
        logic r;
        case (s)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/main_fsm_g7_counter.sv
// Retired-instruction counter: free-running wrap, async active-low clear.
module main_fsm_g7_counter
    import main_fsm_g7_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count value.
    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/main_fsm_g7.sv
// Multicycle main control FSM: decodes the IR opcode, sequences the datapath,
// waits on mem_ready and counts retired instructions.
module main_fsm_g7
    import main_fsm_g7_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    state_e state_q;
    state_e state_d;

    logic pc_update_s, branch_s, ir_write_s, reg_write_s, mem_write_s, illegal_s;
    logic retire_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; only FETCH strobes and illegal look at inputs.
    always_comb begin
        state_d     = S_FETCH;
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                ir_write_s  = mem_ready;
                pc_update_s = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = RES_MEMDATA;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REG;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_REG;
                ALUOp    = ALUOP_SUB;
                branch_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pc_update_s = 1'b1;
                state_d     = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by rst_n so the FETCH mem_ready path cannot leak during reset.
    assign PCUpdate      = pc_update_s & rst_n;
    assign Branch        = branch_s    & rst_n;
    assign IRWrite       = ir_write_s  & rst_n;
    assign RegWrite      = reg_write_s & rst_n;
    assign MemWrite      = mem_write_s & rst_n;
    assign illegal_instr = illegal_s   & rst_n;
    assign state_o       = state_q;

    assign retire_s = is_final_state(state_q) && (state_d == S_FETCH);

    main_fsm_g7_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (retire_s),
        .count_o (retired)
    );

endmodule

// File: tb/tb_main_fsm_g7.sv
// Directed bench for main_fsm_g7: per-cycle expectations go through a scoreboard
// queue; a 3-bit-counter instance shares the stimulus to exercise counter wrap.
module tb_main_fsm_g7;
    import main_fsm_g7_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic        mem_ready;

    logic        PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, illegal_instr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [31:0] retired;
    logic [3:0]  state_o;

    logic        w_PCUpdate, w_Branch, w_IRWrite, w_RegWrite, w_MemWrite, w_AdrSrc, w_illegal;
    logic [1:0]  w_ResultSrc, w_ALUSrcA, w_ALUSrcB, w_ALUOp;
    logic [2:0]  w_retired;
    logic [3:0]  w_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        state_e st;
        logic   mr;
        logic   ill;
        int     ret;
    } exp_t;

    exp_t sb_q[$];

    main_fsm_g7 dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_instr(illegal_instr),
        .retired(retired), .state_o(state_o)
    );

    main_fsm_g7 #(.CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCUpdate(w_PCUpdate), .Branch(w_Branch), .IRWrite(w_IRWrite), .RegWrite(w_RegWrite),
        .MemWrite(w_MemWrite), .AdrSrc(w_AdrSrc), .ResultSrc(w_ResultSrc), .ALUSrcA(w_ALUSrcA),
        .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp), .illegal_instr(w_illegal),
        .retired(w_retired), .state_o(w_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word from the state table:
    // {PCUpdate,Branch,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal}
    function automatic logic [14:0] spec_out(input state_e st, input logic mr, input logic ill);
        logic [14:0] v;
        case (st)
            S_FETCH:    v = {mr,   1'b0, mr,   1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            S_DECODE:   v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, ill};
            S_MEMADR:   v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
            S_MEMREAD:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            S_MEMWB:    v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
            S_MEMWRITE: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            S_EXECUTER: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            S_EXECUTEI: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
            S_ALUWB:    v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
            S_BEQ:      v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
            S_JAL:      v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
            default:    v = 15'd0;
        endcase
        return v;
    endfunction

    function automatic logic [14:0] observed();
        return {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_instr};
    endfunction

    task automatic check_cycle();
        exp_t        e;
        logic [14:0] exp_v;
        e     = sb_q.pop_front();
        exp_v = spec_out(e.st, e.mr, e.ill);
        checks++;
        assert (state_o === 4'(e.st)) else begin
            errors++;
            $error("FAIL state: observed %0d expected %0d", state_o, e.st);
        end
        checks++;
        assert (observed() === exp_v) else begin
            errors++;
            $error("FAIL ctrl(state %0d): observed %b expected %b", e.st, observed(), exp_v);
        end
        checks++;
        assert (retired === 32'(e.ret)) else begin
            errors++;
            $error("FAIL retired: observed %0d expected %0d", retired, e.ret);
        end
        checks++;
        assert (w_retired === 3'(e.ret)) else begin
            errors++;
            $error("FAIL retired_wrap: observed %0d expected %0d", w_retired, 3'(e.ret));
        end
    endtask

    task automatic step(input logic [6:0] o, input logic mr, input state_e st,
                        input logic ill, input int ret);
        exp_t e;
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = mr;
        e.st  = st;
        e.mr  = mr;
        e.ill = ill;
        e.ret = ret;
        sb_q.push_back(e);
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 7'd0;
        mem_ready = 1'b1;
        #22;
        // Under reset: FETCH, counter 0, strobes low despite mem_ready = 1.
        checks++;
        assert (state_o === 4'(S_FETCH)) else begin
            errors++;
            $error("FAIL reset_state: observed %0d expected %0d", state_o, S_FETCH);
        end
        checks++;
        assert (observed() === spec_out(S_FETCH, 1'b0, 1'b0)) else begin
            errors++;
            $error("FAIL reset_ctrl: observed %b expected %b", observed(), spec_out(S_FETCH, 1'b0, 1'b0));
        end
        checks++;
        assert (retired === 32'd0) else begin
            errors++;
            $error("FAIL reset_retired: observed %0d expected 0", retired);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // R-type
        step(OP_R, 1'b1, S_FETCH,    1'b0, 0);
        step(OP_R, 1'b1, S_DECODE,   1'b0, 0);
        step(OP_R, 1'b1, S_EXECUTER, 1'b0, 0);
        step(OP_R, 1'b1, S_ALUWB,    1'b0, 0);
        // I-type
        step(OP_I, 1'b1, S_FETCH,    1'b0, 1);
        step(OP_I, 1'b1, S_DECODE,   1'b0, 1);
        step(OP_I, 1'b1, S_EXECUTEI, 1'b0, 1);
        step(OP_I, 1'b1, S_ALUWB,    1'b0, 1);
        // lw: one fetch wait, three MEMREAD waits
        step(OP_LW, 1'b0, S_FETCH,   1'b0, 2);
        step(OP_LW, 1'b1, S_FETCH,   1'b0, 2);
        step(OP_LW, 1'b1, S_DECODE,  1'b0, 2);
        step(OP_LW, 1'b1, S_MEMADR,  1'b0, 2);
        step(OP_LW, 1'b0, S_MEMREAD, 1'b0, 2);
        step(OP_LW, 1'b0, S_MEMREAD, 1'b0, 2);
        step(OP_LW, 1'b0, S_MEMREAD, 1'b0, 2);
        step(OP_LW, 1'b1, S_MEMREAD, 1'b0, 2);
        step(OP_LW, 1'b1, S_MEMWB,   1'b0, 2);
        // sw: MemWrite held across two wait cycles
        step(OP_SW, 1'b1, S_FETCH,    1'b0, 3);
        step(OP_SW, 1'b1, S_DECODE,   1'b0, 3);
        step(OP_SW, 1'b1, S_MEMADR,   1'b0, 3);
        step(OP_SW, 1'b0, S_MEMWRITE, 1'b0, 3);
        step(OP_SW, 1'b0, S_MEMWRITE, 1'b0, 3);
        step(OP_SW, 1'b1, S_MEMWRITE, 1'b0, 3);
        // beq
        step(OP_BEQ, 1'b1, S_FETCH,  1'b0, 4);
        step(OP_BEQ, 1'b1, S_DECODE, 1'b0, 4);
        step(OP_BEQ, 1'b1, S_BEQ,    1'b0, 4);
        // jal
        step(OP_JAL, 1'b1, S_FETCH,  1'b0, 5);
        step(OP_JAL, 1'b1, S_DECODE, 1'b0, 5);
        step(OP_JAL, 1'b1, S_JAL,    1'b0, 5);
        step(OP_JAL, 1'b1, S_ALUWB,  1'b0, 5);
        // illegal opcode: single pulse, no retire
        step(7'b1111111, 1'b1, S_FETCH,  1'b0, 6);
        step(7'b1111111, 1'b1, S_DECODE, 1'b1, 6);
        // R-type then beq: 3-bit counter wraps 7 -> 0
        step(OP_R, 1'b1, S_FETCH,    1'b0, 6);
        step(OP_R, 1'b1, S_DECODE,   1'b0, 6);
        step(OP_R, 1'b1, S_EXECUTER, 1'b0, 6);
        step(OP_R, 1'b1, S_ALUWB,    1'b0, 6);
        step(OP_BEQ, 1'b1, S_FETCH,  1'b0, 7);
        step(OP_BEQ, 1'b1, S_DECODE, 1'b0, 7);
        step(OP_BEQ, 1'b1, S_BEQ,    1'b0, 7);
        // sw abandoned by reset while in MEMWRITE
        step(OP_SW, 1'b1, S_FETCH,    1'b0, 8);
        step(OP_SW, 1'b1, S_DECODE,   1'b0, 8);
        step(OP_SW, 1'b1, S_MEMADR,   1'b0, 8);
        step(OP_SW, 1'b0, S_MEMWRITE, 1'b0, 8);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (MemWrite === 1'b0) else begin
            errors++;
            $error("FAIL abort_memwrite: observed %b expected 0", MemWrite);
        end
        checks++;
        assert (state_o === 4'(S_FETCH)) else begin
            errors++;
            $error("FAIL abort_state: observed %0d expected %0d", state_o, S_FETCH);
        end
        checks++;
        assert (retired === 32'd0) else begin
            errors++;
            $error("FAIL abort_retired: observed %0d expected 0", retired);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        // beq after reset retires as the first instruction
        step(OP_BEQ, 1'b1, S_FETCH,  1'b0, 0);
        step(OP_BEQ, 1'b1, S_DECODE, 1'b0, 0);
        step(OP_BEQ, 1'b1, S_BEQ,    1'b0, 0);
        step(OP_BEQ, 1'b0, S_FETCH,  1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_fsm_g7.md
Name: main_fsm_g7

Overview:
- Multicycle main control FSM. Sits directly upstream of alu_control_g7: it decodes the opcode held in the instruction register and sequences the datapath.
- Drives ALUOp to alu_control_g7. funct3/funct7 go straight from the IR to alu_control_g7.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Waits on a single-port memory via a mem_ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register; stable from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCUpdate  out  1  PC write strobe
- Branch  out  1  conditional PC write; datapath ANDs it with Zero
- IRWrite  out  1  instruction register / OldPC write strobe
- RegWrite  out  1  register file write strobe
- MemWrite  out  1  data memory write request
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A
- ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4
- ALUOp  out  2  to alu_control_g7: 00 add, 01 sub, 10 funct-decoded
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_W  count of completed instructions
- state_o  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset: state = FETCH, retired = 0.
  - While rst_n = 0, all strobes (PCUpdate, Branch, IRWrite, RegWrite, MemWrite, illegal_instr) are forced to 0.
  - Reset asserted mid-instruction abandons it immediately; the counter is not incremented.
- Output style: Moore outputs, decoded from the state register. Exceptions: the IRWrite/PCUpdate qualification in FETCH, and illegal_instr in DECODE. Any field not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCUpdate = mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op: illegal_instr = 1 for this cycle, next FETCH, counter unchanged.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready = 1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held continuously until mem_ready = 1. Next FETCH on mem_ready.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB (writes PC+4 to rd).
- Latency with mem_ready held at 1: R-type 4, I-type 4, lw 5, sw 4, beq 3, jal 4 cycles. Each FETCH/MEMREAD/MEMWRITE wait cycle adds 1.
- Retired counter:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W with no flag.
- Unused state codes: go to FETCH on the next edge; outputs all 0 while there.

Decomposition:
- Add to riscv_defines_g7.v:
  - state codes S_FETCH .. S_JAL (4-bit)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUOp codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
- Optional sub-module instr_counter_g7: CNT_W counter with increment enable and async active-low clear.

Test Plan:
- R-type: op=0110011, mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=10 in EXECUTER, RegWrite=1 only in ALUWB, retired 0 -> 1.
- lw with 3 wait cycles: mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, AdrSrc=1 throughout, MEMWB follows, total 8 cycles.
- sw: MemWrite held high until mem_ready, RegWrite never asserted; beq -> Branch=1 and ALUOp=01 in BEQ, 3 cycles total.
- jal: PCUpdate=1 in JAL with ALUSrcA=01 and ALUSrcB=10, then RegWrite in ALUWB, retired increments once.
- Illegal op=1111111 -> illegal_instr pulses 1 cycle in DECODE, back to FETCH, retired unchanged.
- rst_n low in MEMWRITE -> MemWrite drops to 0 immediately, state_o = FETCH; counter preset to 0xFFFFFFFF wraps to 0 on next retire.
